// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
// Channels derive their divisor limits and state layout from here.
package clkdiv_pkg;

  localparam int DEF_CNT_W = 33;
  localparam int MIN_DIV   = 2;
  localparam int DEF_DIV   = 10000;

  // Per-channel state at the default counter width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_CNT_W-1:0] div_active;
    logic [DEF_CNT_W-1:0] div_pending;
    logic                 pend_vld;
  } chan_state_t;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int ch_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, pending-divisor slot and registered
// out_clk/tick. A divisor change only lands on a period boundary.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             busy,
  output logic             out_clk,
  output logic             tick
);

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_pending;
    logic             pend_vld;
  } state_t;

  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] RST_D = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_reg, state_next;
  logic             out_reg, out_next;
  logic             tick_reg, tick_next;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] wrap_div;
  logic [CNT_W-1:0] count_new;
  logic [CNT_W-1:0] div_new;
  logic             wrap;

  always_comb begin
    div_clamped = (wr_div < MIN_D) ? MIN_D : wr_div;
    wrap        = (state_reg.count == state_reg.div_active - ONE);
    // The divisor that governs the period starting at the next boundary.
    wrap_div    = state_reg.pend_vld ? state_reg.div_pending : state_reg.div_active;
    count_new   = wrap ? '0 : state_reg.count + ONE;
    div_new     = wrap ? wrap_div : state_reg.div_active;
  end

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    tick_next  = 1'b0;
    if (restart) begin
      state_next.div_active = wrap_div;
      state_next.pend_vld   = 1'b0;
      state_next.count      = '0;
      out_next              = 1'b1;
      tick_next             = en;
    end else if (wr && !en) begin
      state_next.div_active = div_clamped;
      state_next.count      = div_clamped - ONE;
    end else if (en) begin
      state_next.count      = count_new;
      state_next.div_active = div_new;
      if (wrap) begin
        state_next.pend_vld = 1'b0;
      end
      out_next  = (count_new < (div_new >> 1));
      tick_next = wrap;
    end
    // Writes against a running (or restarting) channel wait for a boundary.
    if (wr && (restart || en)) begin
      state_next.div_pending = div_clamped;
      state_next.pend_vld    = 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      state_reg <= '{count: RST_D - ONE, div_active: RST_D, div_pending: '0, pend_vld: 1'b0};
      out_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      tick_reg  <= tick_next;
    end
  end

  assign busy    = state_reg.pend_vld;
  assign out_clk = out_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider: one clkdiv_channel per
// output plus the shared config port decode and ready mux.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter  int          CHANNELS    = 4,
  parameter  int          CNT_W       = DEF_CNT_W,
  parameter  int unsigned DEFAULT_DIV = DEF_DIV,
  localparam int          CH_W        = ch_idx_w(CHANNELS)
) (
  input  logic                in_clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_restart,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic                cfg_ready,
  output logic [CHANNELS-1:0] out_clk,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0]      busy;
  logic [(1 << CH_W)-1:0]   busy_ext;
  logic                     cfg_accept;

  // Unused index codes read as idle, so writes to them are accepted and dropped.
  always_comb begin
    busy_ext                 = '0;
    busy_ext[CHANNELS-1:0]   = busy;
  end

  assign cfg_ready  = ~busy_ext[cfg_ch];
  assign cfg_accept = cfg_valid & cfg_ready;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      clkdiv_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .in_clk  (in_clk),
        .rst_n   (rst_n),
        .en      (en[gi]),
        .restart (sync_restart),
        .wr      (cfg_accept && (cfg_ch == CH_W'(gi))),
        .wr_div  (cfg_div),
        .busy    (busy[gi]),
        .out_clk (out_clk[gi]),
        .tick    (tick[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed scenarios with literal
// period/phase expectations, then randomized traffic against a period/phase model.
module tb_prog_clock_divider;

  localparam int CH   = 2;
  localparam int W    = 33;
  localparam int DDIV = 10;

  logic          in_clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          sync_restart;
  logic          cfg_valid;
  logic [0:0]    cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_ready;
  logic [CH-1:0] out_clk;
  logic [CH-1:0] tick;

  int checks = 0;
  int errors = 0;

  prog_clock_divider #(
    .CHANNELS    (CH),
    .CNT_W       (W),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .in_clk       (in_clk),
    .rst_n        (rst_n),
    .en           (en),
    .sync_restart (sync_restart),
    .cfg_valid    (cfg_valid),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_ready    (cfg_ready),
    .out_clk      (out_clk),
    .tick         (tick)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a period length plus a phase position in it.
  longint m_period[CH];
  longint m_phase[CH];
  longint m_pdiv[CH];
  bit     m_pend[CH];
  bit     m_out[CH];
  bit     m_tick[CH];
  bit     m_live = 1'b0;

  function automatic longint clamp(input longint d);
    return (d < 2) ? 2 : d;
  endfunction

  always @(posedge in_clk) begin : model
    bit acc;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_period[c] = DDIV;
        m_phase[c]  = DDIV - 1;
        m_pend[c]   = 1'b0;
        m_pdiv[c]   = 0;
        m_out[c]    = 1'b0;
        m_tick[c]   = 1'b0;
      end
      m_live = 1'b1;
    end else begin
      acc = cfg_valid && !m_pend[cfg_ch];
      for (int c = 0; c < CH; c++) begin
        bit wr_c;
        wr_c = acc && (int'(cfg_ch) == c);
        if (sync_restart) begin
          if (m_pend[c]) m_period[c] = m_pdiv[c];
          m_pend[c]  = 1'b0;
          m_phase[c] = 0;
          m_out[c]   = 1'b1;
          m_tick[c]  = en[c];
          if (wr_c) begin
            m_pend[c] = 1'b1;
            m_pdiv[c] = clamp(longint'(cfg_div));
          end
        end else if (en[c]) begin
          if (m_phase[c] == m_period[c] - 1) begin
            if (m_pend[c]) m_period[c] = m_pdiv[c];
            m_pend[c]  = 1'b0;
            m_phase[c] = 0;
            m_tick[c]  = 1'b1;
          end else begin
            m_phase[c] = m_phase[c] + 1;
            m_tick[c]  = 1'b0;
          end
          m_out[c] = (m_phase[c] < m_period[c] / 2);
          if (wr_c) begin
            m_pend[c] = 1'b1;
            m_pdiv[c] = clamp(longint'(cfg_div));
          end
        end else begin
          m_tick[c] = 1'b0;
          if (wr_c) begin
            m_period[c] = clamp(longint'(cfg_div));
            m_phase[c]  = m_period[c] - 1;
          end
        end
      end
    end
  end

  always @(negedge in_clk) begin
    if (m_live) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("model out_clk[%0d]", c), longint'(out_clk[c]), longint'(m_out[c]));
        check($sformatf("model tick[%0d]", c), longint'(tick[c]), longint'(m_tick[c]));
      end
      check("model cfg_ready", longint'(cfg_ready), longint'(!m_pend[cfg_ch]));
    end
  end

  task automatic step();
    @(negedge in_clk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input longint d);
    cfg_ch    = ch[0:0];
    cfg_div   = W'(d);
    cfg_valid = 1'b1;
    #1;
    check("ready before write", longint'(cfg_ready), 1);
    $display("cfg write ch%0d div=%0d", ch, d);
    step();
    cfg_valid = 1'b0;
  endtask

  // Cycles until tick on channel ch (-1 on timeout) and out_clk-high samples seen.
  task automatic wait_tick(input int ch, input int maxc, output int n, output int highs);
    bit done;
    done  = 1'b0;
    n     = -1;
    highs = 0;
    for (int k = 1; k <= maxc && !done; k++) begin
      step();
      if (out_clk[ch]) highs++;
      if (tick[ch]) begin
        n    = k;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int n, h;
    rst_n        = 1'b0;
    en           = '0;
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = '0;
    cfg_div      = '0;
    repeat (3) step();
    check("reset out_clk", longint'(out_clk), 0);
    check("reset tick", longint'(tick), 0);
    check("reset cfg_ready", longint'(cfg_ready), 1);

    // Default period from reset: first enabled edge wraps.
    rst_n = 1'b1;
    en    = 2'b11;
    wait_tick(0, 20, n, h);
    check("t1 first tick edge", n, 1);
    wait_tick(0, 20, n, h);
    check("t1 period", n, 10);
    check("t1 high cycles", h, 5);

    // Divisor 7 written at count 3 lands after the current 10-cycle period.
    repeat (3) step();
    write_cfg(0, 7);
    check("t2 ch0 busy", longint'(cfg_ready), 0);
    cfg_ch = 1'b1;
    #1;
    check("t2 ch1 ready", longint'(cfg_ready), 1);
    cfg_ch = 1'b0;
    wait_tick(0, 20, n, h);
    check("t2 rest of old period", n, 6);
    wait_tick(0, 20, n, h);
    check("t2 new period", n, 7);
    check("t2 new high cycles", h, 3);

    // Divisors 0 and 1 clamp to 2.
    write_cfg(1, 0);
    wait_tick(1, 20, n, h);
    wait_tick(1, 5, n, h);
    check("t3 div0 period", n, 2);
    check("t3 div0 high", h, 1);
    write_cfg(1, 1);
    wait_tick(1, 20, n, h);
    wait_tick(1, 5, n, h);
    check("t3 div1 period", n, 2);
    check("t3 div1 high", h, 1);

    // Freeze mid-high for 4 cycles on a 10-cycle period.
    write_cfg(0, 10);
    wait_tick(0, 20, n, h);
    step();
    en[0] = 1'b0;
    repeat (4) begin
      step();
      check("t4 frozen out_clk", longint'(out_clk[0]), 1);
      check("t4 frozen tick", longint'(tick[0]), 0);
    end
    en[0] = 1'b1;
    wait_tick(0, 20, n, h);
    check("t4 stretched period", 5 + n, 14);
    en[0] = 1'b0;
    write_cfg(0, 5);
    step();
    en[0] = 1'b1;
    wait_tick(0, 3, n, h);
    check("t4 tick on first enable", n, 1);
    wait_tick(0, 10, n, h);
    check("t4 immediate period", n, 5);
    check("t4 immediate high", h, 2);

    // sync_restart applies a pending divisor and aligns both channels.
    write_cfg(0, 10);
    write_cfg(1, 7);
    repeat (30) step();
    write_cfg(1, 4);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("t5 restart tick", longint'(tick), 3);
    check("t5 restart out_clk", longint'(out_clk), 3);
    wait_tick(1, 10, n, h);
    check("t5 adopted period", n, 4);
    check("t5 adopted high", h, 2);

    // Reset mid-period discards a pending write.
    write_cfg(0, 3);
    rst_n = 1'b0;
    step();
    check("t6 reset out_clk", longint'(out_clk), 0);
    check("t6 reset tick", longint'(tick), 0);
    check("t6 reset ready", longint'(cfg_ready), 1);
    rst_n = 1'b1;
    wait_tick(0, 3, n, h);
    check("t6 first tick", n, 1);
    wait_tick(0, 20, n, h);
    check("t6 default period", n, 10);
    check("t6 default high", h, 5);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      en[0]        = ($urandom_range(0, 7) != 0);
      en[1]        = ($urandom_range(0, 7) != 0);
      sync_restart = ($urandom_range(0, 63) == 0);
      cfg_valid    = ($urandom_range(0, 5) == 0);
      cfg_ch       = 1'($urandom_range(0, 1));
      cfg_div      = W'($urandom_range(0, 12));
      #1;
      if (cfg_valid && cfg_ready && rst_n)
        $display("cfg write ch%0d div=%0d en=%b restart=%0b", cfg_ch, cfg_div, en, sync_restart);
      step();
    end
    cfg_valid    = 1'b0;
    sync_restart = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Multi-channel, runtime-programmable clock divider. It is the parametrised successor to the fixed single-channel divider. Each channel derives a divided square wave and a one-cycle tick strobe from in_clk. The divisor is loaded at run time through a valid/ready config port and applied glitch-free at the next period boundary. It sits between the board clock and the slow-rate consumers: display refresh, debouncers, game timers.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
CNT_W, 33, counter and divisor width in bits
DEFAULT_DIV, 10000, divisor loaded into every channel at reset; must be at least 2 and fit in CNT_W

Ports:
in_clk  input  1  system clock, 100 MHz; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
en  input  CHANNELS  per-channel count enable
sync_restart  input  1  one-cycle pulse; phase-aligns all channels
cfg_valid  input  1  config write request
cfg_ch  input  max(1,$clog2(CHANNELS))  target channel index
cfg_div  input  CNT_W  requested divisor (period in in_clk cycles)
cfg_ready  output  1  config write accepted this cycle when high with cfg_valid
out_clk  output  CHANNELS  divided clock per channel, registered
tick  output  CHANNELS  one-cycle strobe at the start of each period, registered

Behaviour:
- Reset (rst_n=0 at an edge):
  - Every channel: div_active=DEFAULT_DIV, count=DEFAULT_DIV-1, pending empty.
  - out_clk=0, tick=0.
  - cfg_ready is 1 after reset.
- Counting (en[i]=1):
  - count_i advances by 1 per edge.
  - When count_i = div_active_i-1, the next value is 0 (wrap).
  - First enabled edge after reset wraps, so tick and out_clk rise together.
- Registered outputs, computed from the new count value on the same edge:
  - out_clk_i = (count_new < div_active_i/2), floor division.
  - tick_i = 1 only on the wrap edge.
  - Odd D: high floor(D/2) cycles, low ceil(D/2) cycles.
- Hold (en[i]=0): count_i and out_clk_i hold; tick_i=0.
- Divisor clamp: cfg_div values 0 and 1 are stored as 2 (MIN_DIV). There is no other range check.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch]; this is combinational from registers and cfg_ch.
  - A write is accepted on an edge with cfg_valid & cfg_ready.
  - If en[ch]=1: the value goes to pending and is applied on that channel's next wrap edge. That wrap uses the new div_active for the out_clk compare, and pending clears.
  - If en[ch]=0: div_active loads immediately, count=div-1, and pending stays empty.
  - cfg_ch >= CHANNELS: the write is accepted and discarded.
- Simultaneous events:
  - Accepted write on the same edge as a wrap: the value goes to pending and takes effect at the following wrap. The current wrap keeps the old divisor.
  - Priority: rst_n > sync_restart > config > counting.
- sync_restart:
  - All channels: pending (if any) is applied, then count=0.
  - Channels with en=1: tick=1, out_clk=1.
  - Channels with en=0: count=0 and out_clk=1, tick=0.
  - A config write on the same edge is accepted and left pending.
- Reset mid-period: immediate return to reset state; pending writes are lost.
- Arithmetic: all compares are unsigned CNT_W-bit; no overflow is possible since count < div_active.

Decomposition:
- Package clkdiv_pkg: CNT_W default, MIN_DIV=2, DEFAULT_DIV, and a channel-state struct (count, div_active, div_pending, pend_vld).
- Sub-module clkdiv_channel: one channel's counter, pending register, clamp and output regs. Ports: in_clk, rst_n, en, restart, wr, wr_div, busy, out_clk, tick.
- Top level: generate loop, cfg_ch decode, cfg_ready mux.

Test Plan:
1. CHANNELS=2, DEFAULT_DIV=10; release rst_n, en=2'b11 -> tick on cycles 1,11,21...; out_clk high 5 cycles, low 5, both channels identical.
2. Write cfg_ch=0, cfg_div=7 at count=3 -> ch0 finishes its 10-cycle period, then period 7 (high 3, low 4); cfg_ready low for ch0 until that wrap, high for ch1 throughout.
3. Write cfg_div=0 and, separately, cfg_div=1 to ch1 -> period 2, out_clk alternates 1/0 each cycle, tick every 2nd cycle.
4. Deassert en[0] for 4 cycles mid-high phase -> count and out_clk frozen, tick 0; period resumes and totals 14 cycles; a write while disabled applies at once with tick on the first enabled edge.
5. Ch0 div 10, ch1 div 7 drifting; pulse sync_restart with a pending write on ch1 -> both tick and out_clk=1 on the same edge; ch1 adopts the pending divisor immediately.
6. Assert rst_n=0 for 1 cycle mid-period with a pending write -> out_clk=0, tick=0, pending discarded; the next period length is DEFAULT_DIV.
